// File: rtl/tri_bus_arbiter_pkg.sv
// Shared types and widths for the tristate bus arbiter.
package tri_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_t;

   localparam int unsigned TURN_W = 3;
   localparam int unsigned HOLD_W = 8;

   function automatic int unsigned ptr_width(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/tri_bus_arbiter_if.sv
// Request/grant/enable bundle between requesters and the arbiter.
interface tri_bus_arbiter_if #(
   parameter int unsigned N = 4
) ();
   logic [N-1:0] REQ;
   logic [N-1:0] GNT;
   logic [N-1:0] ENA;
   logic         BUSY;
   logic         TIMEOUT;

   modport master (input REQ, output GNT, output ENA, output BUSY, output TIMEOUT);
   modport slave  (output REQ, input GNT, input ENA, input BUSY, input TIMEOUT);
endinterface

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or above ptr_i, wrapping.
import tri_bus_arbiter_pkg::*;

module rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     win_o,
   output logic             valid_o
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      win_o   = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = PTR_W'((32'(ptr_i) + i) % N);
         if (!valid_o && req_i[idx]) begin
            win_o[idx] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus with enforced turnaround.
// Optional hold-timeout revoke enabled by defining TRI_BUS_ARBITER_TIMEOUT_EN.
import tri_bus_arbiter_pkg::*;

module tri_bus_arbiter #(
   parameter int unsigned N           = 4,
   parameter int unsigned TURN_CYCLES = 1,
   parameter int unsigned MAX_HOLD    = 8
) (
   input  logic              CLK,
   input  logic              RST,
   tri_bus_arbiter_if.master bus
);

   localparam int unsigned PTR_W = ptr_width(N);

   if (N < 2 || N > 16 || TURN_CYCLES < 1 || TURN_CYCLES > 7 ||
       MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
      $error("tri_bus_arbiter: parameter out of legal range");
   end

   arb_state_t        state_q, state_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [TURN_W-1:0] turn_q, turn_d;
   logic              busy_q, busy_d;
   logic [N-1:0]      win;
   logic              win_vld;
   logic [PTR_W-1:0]  win_idx, ptr_after;
   logic              holder_req, arb_now;
`ifdef TRI_BUS_ARBITER_TIMEOUT_EN
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              timeout_q, timeout_d;
   logic              other_req;
`endif

   rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
      .req_i   (bus.REQ),
      .ptr_i   (ptr_q),
      .win_o   (win),
      .valid_o (win_vld)
   );

   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (win[i]) win_idx = PTR_W'(i);
      end
   end

   assign ptr_after  = (win_idx == PTR_W'(N - 1)) ? '0 : win_idx + 1'b1;
   assign holder_req = |(bus.REQ & gnt_q);
   // Arbitration happens from IDLE and on the last turnaround cycle only.
   assign arb_now    = (state_q == IDLE) ||
                       (state_q == TURN && turn_q == TURN_W'(TURN_CYCLES - 1));
`ifdef TRI_BUS_ARBITER_TIMEOUT_EN
   assign other_req  = |(bus.REQ & ~gnt_q);
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      turn_d  = turn_q;
`ifdef TRI_BUS_ARBITER_TIMEOUT_EN
      hold_d    = hold_q;
      timeout_d = 1'b0;
`endif
      unique case (state_q)
         IDLE, TURN: begin
            if (arb_now) begin
               if (win_vld) begin
                  state_d = GRANT;
                  gnt_d   = win;
                  ptr_d   = ptr_after;
`ifdef TRI_BUS_ARBITER_TIMEOUT_EN
                  hold_d  = '0;
`endif
               end else begin
                  state_d = IDLE;
               end
            end else begin
               turn_d = turn_q + 1'b1;
            end
         end
         GRANT: begin
            if (!holder_req) begin
               state_d = TURN;
               gnt_d   = '0;
               turn_d  = '0;
            end
`ifdef TRI_BUS_ARBITER_TIMEOUT_EN
            // Revoke only when someone else is waiting; pointer already points past holder.
            else if (hold_q >= HOLD_W'(MAX_HOLD - 1) && other_req) begin
               state_d   = TURN;
               gnt_d     = '0;
               turn_d    = '0;
               timeout_d = 1'b1;
            end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
               hold_d = hold_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         turn_q  <= '0;
         busy_q  <= 1'b0;
`ifdef TRI_BUS_ARBITER_TIMEOUT_EN
         hold_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         turn_q  <= turn_d;
         busy_q  <= busy_d;
`ifdef TRI_BUS_ARBITER_TIMEOUT_EN
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign bus.GNT  = gnt_q;
   assign bus.ENA  = gnt_q;
   assign bus.BUSY = busy_q;
`ifdef TRI_BUS_ARBITER_TIMEOUT_EN
   assign bus.TIMEOUT = timeout_q;
`else
   assign bus.TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed scoreboard bench for tri_bus_arbiter (TURN_CYCLES=1 and TURN_CYCLES=3 instances).
module tb_tri_bus_arbiter;

   typedef struct {
      bit         sel;
      logic [3:0] gnt;
      logic       busy;
      logic       to;
   } exp_t;

   logic CLK;
   logic RST;
   exp_t sb[$];
   int unsigned total;
   int unsigned pass_cnt;

   tri_bus_arbiter_if #(.N(4)) bus1 ();
   tri_bus_arbiter_if #(.N(4)) bus3 ();

   tri_bus_arbiter #(.N(4), .TURN_CYCLES(1), .MAX_HOLD(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus1)
   );

   tri_bus_arbiter #(.N(4), .TURN_CYCLES(3), .MAX_HOLD(8)) dut3 (
      .CLK (CLK),
      .RST (RST),
      .bus (bus3)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step(input bit sel, input logic rst, input logic [3:0] req,
                       input logic [3:0] gnt, input logic busy, input logic to);
      exp_t e;
      logic [3:0] g, en;
      logic b, t;
      RST = rst;
      if (sel) bus3.REQ = req;
      else     bus1.REQ = req;
      e.sel = sel; e.gnt = gnt; e.busy = busy; e.to = to;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      if (e.sel) begin
         g = bus3.GNT; en = bus3.ENA; b = bus3.BUSY; t = bus3.TIMEOUT;
      end else begin
         g = bus1.GNT; en = bus1.ENA; b = bus1.BUSY; t = bus1.TIMEOUT;
      end
      chk("gnt", 32'(g), 32'(e.gnt));
      chk("ena", 32'(en), 32'(e.gnt));
      chk("ena_onehot", 32'($countones(en) <= 1), 32'd1);
      chk("busy", 32'(b), 32'(e.busy));
      chk("timeout", 32'(t), 32'(e.to));
   endtask

   initial begin
      logic [3:0] h, nx;
      CLK = 1'b0;
      RST = 1'b1;
      bus1.REQ = '0;
      bus3.REQ = '0;
      total = 0;
      pass_cnt = 0;

      // 1: reset state
      step(0, 1, 4'b0000, 4'b0000, 0, 0);
      step(0, 1, 4'b0000, 4'b0000, 0, 0);
      step(0, 0, 4'b0000, 4'b0000, 0, 0);

      // 2: grant latency and single-cycle turnaround
      step(0, 0, 4'b0101, 4'b0001, 1, 0);
      step(0, 0, 4'b0100, 4'b0000, 1, 0);
      step(0, 0, 4'b0100, 4'b0100, 1, 0);
      step(0, 0, 4'b0000, 4'b0000, 1, 0);
      step(0, 0, 4'b0000, 4'b0000, 0, 0);

      // 3: round robin over all requesters, each holding 2 cycles
      step(0, 1, 4'b0000, 4'b0000, 0, 0);
      step(0, 0, 4'b1111, 4'b0001, 1, 0);
      for (int i = 0; i < 4; i++) begin
         h  = 4'b0001 << i;
         nx = 4'b0001 << ((i + 1) % 4);
         step(0, 0, 4'b1111, h, 1, 0);
         step(0, 0, 4'b1111 & ~h, 4'b0000, 1, 0);
         step(0, 0, 4'b1111, nx, 1, 0);
      end
      step(0, 0, 4'b0000, 4'b0000, 1, 0);
      step(0, 0, 4'b0000, 4'b0000, 0, 0);

      // 4: three-cycle turnaround
      step(1, 0, 4'b0001, 4'b0001, 1, 0);
      step(1, 0, 4'b0010, 4'b0000, 1, 0);
      step(1, 0, 4'b0010, 4'b0000, 1, 0);
      step(1, 0, 4'b0010, 4'b0000, 1, 0);
      step(1, 0, 4'b0010, 4'b0010, 1, 0);
      step(1, 0, 4'b0000, 4'b0000, 1, 0);
      step(1, 0, 4'b0000, 4'b0000, 1, 0);
      step(1, 0, 4'b0000, 4'b0000, 1, 0);
      step(1, 0, 4'b0000, 4'b0000, 0, 0);

      // 5: long hold with a competing request
      step(0, 1, 4'b0000, 4'b0000, 0, 0);
      step(0, 0, 4'b0010, 4'b0010, 1, 0);
      step(0, 0, 4'b0010, 4'b0010, 1, 0);
      for (int c = 3; c <= 8; c++) step(0, 0, 4'b0110, 4'b0010, 1, 0);
`ifdef TRI_BUS_ARBITER_TIMEOUT_EN
      step(0, 0, 4'b0110, 4'b0000, 1, 1);
      step(0, 0, 4'b0110, 4'b0100, 1, 0);
`else
      for (int c = 0; c < 4; c++) step(0, 0, 4'b0110, 4'b0010, 1, 0);
      step(0, 0, 4'b0100, 4'b0000, 1, 0);
      step(0, 0, 4'b0100, 4'b0100, 1, 0);
`endif
      for (int c = 0; c < 12; c++) step(0, 0, 4'b0100, 4'b0100, 1, 0);
      step(0, 0, 4'b0000, 4'b0000, 1, 0);
      step(0, 0, 4'b0000, 4'b0000, 0, 0);

      // 6: reset mid-grant clears enables and pointer
      step(0, 1, 4'b0000, 4'b0000, 0, 0);
      step(0, 0, 4'b0010, 4'b0010, 1, 0);
      step(0, 1, 4'b0110, 4'b0000, 0, 0);
      step(0, 0, 4'b0110, 4'b0010, 1, 0);
      step(0, 0, 4'b0000, 4'b0000, 1, 0);
      step(0, 0, 4'b0000, 4'b0000, 0, 0);
      step(0, 0, 4'b1000, 4'b1000, 1, 0);
      step(0, 1, 4'b1001, 4'b0000, 0, 0);
      step(0, 0, 4'b1001, 4'b0001, 1, 0);
      step(0, 0, 4'b0000, 4'b0000, 1, 0);
      step(0, 0, 4'b0000, 4'b0000, 0, 0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
